ring_phase_monitor: RTL
=======================

Name: ring_phase_monitor

Overview:
- Receive-side checker for a one-hot ring-counter phase bus, sampled on the same clock as the ring.
- Validates the one-hot encoding and the rotation order, and decodes the phase to a binary index.
- Achieves lock after a run of correct rotations, counts completed rotations, and flags and counts ordering faults.
- Sits downstream of any ring-sequenced block, e.g. for phase-sequencer health monitoring in the lab designs.

Parameters:
- WIDTH, 4, ring width (number of phases); must be >= 2.
- LOCK_COUNT, 4, consecutive correct successor transitions required to reach LOCKED.
- ERR_W, 8, width of the saturating error counter.
- ROT_W, 16, width of the wrapping rotation counter.

Ports:
- cp  in  1  clock; all logic on posedge cp.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on posedge cp).
- in_valid  in  1  ring_in is a sample to check this cycle.
- ring_in  in  WIDTH  phase vector from the ring counter.
- clear_err  in  1  clears err_sticky and err_count.
- phase_idx  out  clog2(WIDTH)  index of the hot bit of the last legal sample.
- phase_valid  out  1  last accepted sample was a legal one-hot.
- locked  out  1  state == LOCKED.
- err_pulse  out  1  one-cycle pulse on an ordering or encoding fault while LOCKED.
- err_sticky  out  1  set on err_pulse; held until clear_err.
- err_count  out  ERR_W  fault count, saturates at all-ones.
- rot_count  out  ROT_W  completed rotations while LOCKED, wraps.
- resync_pulse  out  1  one-cycle pulse on a legal reseed while LOCKED.

Behaviour:
- Reset (reset=0 at posedge): state=HUNT, ref=0, good_cnt=0, and all outputs 0. Reset overrides every other input.
- SEED is the one-hot vector with only the MSB set (1000 for WIDTH=4). This is the value the ring loads on its own reset.
- Rotation is a right shift: succ(v) = {v[0], v[WIDTH-1:1]}, giving 1000 -> 0100 -> 0010 -> 0001 -> 1000.
- A sample is legal when exactly one bit is set; 0 and multi-hot vectors are illegal.
- in_valid=0: nothing advances. State, ref and counters hold, and the pulses deassert.
- Latency: every output is registered and reflects the sample accepted on the previous posedge.
- On a legal sample: ref <= ring_in, phase_idx <= index of the hot bit, phase_valid <= 1.
- On an illegal sample: phase_valid <= 0, phase_idx holds, ref <= 0.
- HUNT:
  - legal sample -> CHECK with good_cnt=0.
  - illegal sample -> stay in HUNT.
- CHECK (ref valid):
  - sample == succ(ref) -> good_cnt+1; when good_cnt reaches LOCK_COUNT, go to LOCKED.
  - sample == SEED but != succ(ref) -> reseed: stay in CHECK, good_cnt=0.
  - any other legal sample -> stay in CHECK, good_cnt=0.
  - illegal sample -> HUNT.
- LOCKED:
  - sample == succ(ref) -> stay; if the sample is SEED (a wrap from LSB-hot), rot_count+1.
  - sample == SEED but != succ(ref) -> stay, resync_pulse=1, no rot_count increment.
  - any other sample, legal or illegal -> FAULT, err_pulse=1, err_sticky=1, err_count+1 (saturating).
- FAULT lasts one cycle, then HUNT unconditionally. A sample arriving during FAULT is ignored and not checked.
- locked deasserts on the cycle FAULT is entered.
- A repeated identical sample (ring stalled) while in_valid=1 is an ordering fault in LOCKED. Upstream must gate in_valid when the ring holds.
- clear_err together with a new fault: the fault wins, giving err_sticky=1 and err_count=1.
- rot_count is not cleared by clear_err, only by reset.
- WIDTH=2 edge case: SEED == succ(01), so resync_pulse only fires from ref=10 -> 10, which is already a fault. The fault takes priority over a reseed.

Decomposition:
- Shared package holds:
  - state encoding: HUNT, CHECK, LOCKED, FAULT;
  - SEED and succ() as functions of WIDTH;
  - an onehot_legal function.
- One sub-module is natural: onehot_decode, which is combinational, outputs legal and idx, and uses a priority-free OR-reduce per index bit.

Test Plan:
- Reset held low 2 cycles, then released; ring_in=1000,0100,0010,0001,1000 with in_valid=1. Required: phase_idx 3,2,1,0,3; locked rises one cycle after the 5th sample (LOCK_COUNT=4); rot_count=0.
- Locked, continue 0100,0010,0001,1000. Required: rot_count=1 one cycle after the 1000 sample; no err_pulse.
- Locked at ref=0010, inject 1000. Required: resync_pulse=1 for 1 cycle; locked stays 1; err_count=0.
- Locked at ref=0100, inject 0110. Required: err_pulse=1, err_sticky=1, err_count=1, phase_valid=0, locked=0; next cycle state HUNT; then 4 correct rotations relock.
- Sticky set with err_count=1: assert clear_err in the same cycle as a new fault. Required: err_sticky=1, err_count=1; clear_err alone next cycle gives 0/0.
- 260 forced faults. Required: err_count saturates at 255; reset=0 mid-CHECK clears all outputs on the next posedge, with in_valid ignored.

Source files
------------

// File: rtl/ring_phase_monitor_pkg.sv
// rtl/ring_phase_monitor_pkg.sv - shared state encoding and ring helpers for ring_phase_monitor
// Purpose: FSM state constants plus width-generic SEED, successor and one-hot
//          legality helpers. Vectors are carried zero-extended to MAX_W bits so
//          one set of functions serves every WIDTH up to MAX_W.
// Ports:   none (package)
package ring_phase_monitor_pkg;

  localparam int MAX_W = 32;

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_CHECK  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;
  localparam logic [1:0] ST_FAULT  = 2'd3;

  localparam logic [MAX_W-1:0] ONE_V = MAX_W'(1);

  // Vector the ring loads on its own reset: only the MSB of a w-wide ring set.
  function automatic logic [MAX_W-1:0] seed_vec(input int w);
    logic [MAX_W-1:0] r;
    r = '0;
    r[w-1] = 1'b1;
    return r;
  endfunction

  // Right rotation within a w-wide ring; bits at and above w must be zero.
  function automatic logic [MAX_W-1:0] succ_vec(input logic [MAX_W-1:0] v, input int w);
    logic [MAX_W-1:0] r;
    r = v >> 1;
    r[w-1] = v[0];
    return r;
  endfunction

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  function automatic logic onehot_legal(input logic [MAX_W-1:0] v);
    return (v != '0) && ((v & (v - ONE_V)) == '0);
  endfunction

endpackage

// File: rtl/ring_phase_monitor_onehot_decode.sv
// rtl/ring_phase_monitor_onehot_decode.sv - combinational one-hot legality check and index encoder
// Purpose: flags whether vec is a legal one-hot and encodes the hot bit position.
// Ports:   vec   - phase vector under test
//          legal - exactly one bit of vec is set
//          idx   - binary index of the hot bit (meaningful only when legal)
module ring_phase_monitor_onehot_decode
  import ring_phase_monitor_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int IDX_W = 2
) (
  input  logic [WIDTH-1:0] vec,
  output logic             legal,
  output logic [IDX_W-1:0] idx
);

  // Each index bit is the OR of every input position whose index has that bit
  // set; no priority chain, since only legal (single-hot) inputs are used.
  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int b = 0; b < IDX_W; b++) begin
        if (((i >> b) & 1) != 0) begin
          idx[b] = idx[b] | vec[i];
        end
      end
    end
    legal = onehot_legal(MAX_W'(vec));
  end

endmodule

// File: rtl/ring_phase_monitor.sv
// rtl/ring_phase_monitor.sv - one-hot ring-counter phase checker with lock, rotation and fault tracking
// Purpose: validates a one-hot ring phase bus sampled on cp, decodes the phase
//          index, locks after LOCK_COUNT correct successor steps, counts
//          rotations while locked and flags/counts ordering or encoding faults.
// Ports:   cp           - clock, all logic on rising edge
//          reset        - synchronous active-low reset
//          in_valid     - ring_in carries a sample this cycle
//          ring_in      - phase vector from the ring counter
//          clear_err    - clears err_sticky and err_count
//          phase_idx    - index of the hot bit of the last legal sample
//          phase_valid  - last accepted sample was legal
//          locked       - monitor is in LOCKED
//          err_pulse    - one-cycle fault indication while locked
//          err_sticky   - held fault flag until clear_err
//          err_count    - saturating fault count
//          rot_count    - wrapping count of completed rotations while locked
//          resync_pulse - one-cycle pulse on a legal reseed while locked
module ring_phase_monitor
  import ring_phase_monitor_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 4,
  parameter int ERR_W      = 8,
  parameter int ROT_W      = 16
) (
  input  logic                     cp,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         ring_in,
  input  logic                     clear_err,
  output logic [$clog2(WIDTH)-1:0] phase_idx,
  output logic                     phase_valid,
  output logic                     locked,
  output logic                     err_pulse,
  output logic                     err_sticky,
  output logic [ERR_W-1:0]         err_count,
  output logic [ROT_W-1:0]         rot_count,
  output logic                     resync_pulse
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int GC_W  = $clog2(LOCK_COUNT + 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] ref_q;
  logic [GC_W-1:0]  good_cnt;

  logic             dec_legal;
  logic [IDX_W-1:0] dec_idx;
  logic             is_succ;
  logic             is_seed;
  logic             is_stall;

  ring_phase_monitor_onehot_decode #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_decode (
    .vec   (ring_in),
    .legal (dec_legal),
    .idx   (dec_idx)
  );

  always_comb begin
    is_succ  = (MAX_W'(ring_in) == succ_vec(MAX_W'(ref_q), WIDTH));
    is_seed  = (MAX_W'(ring_in) == seed_vec(WIDTH));
    // A repeated sample is a stall; it must fault even when it equals SEED
    // (the only way a reseed could look legal for WIDTH=2).
    is_stall = (ring_in == ref_q);
  end

  assign locked = (state == ST_LOCKED);

  always_ff @(posedge cp) begin
    if (!reset) begin
      state        <= ST_HUNT;
      ref_q        <= '0;
      good_cnt     <= '0;
      phase_idx    <= '0;
      phase_valid  <= 1'b0;
      err_pulse    <= 1'b0;
      err_sticky   <= 1'b0;
      err_count    <= '0;
      rot_count    <= '0;
      resync_pulse <= 1'b0;
    end else begin
      err_pulse    <= 1'b0;
      resync_pulse <= 1'b0;

      // A fault in the same cycle overrides these below.
      if (clear_err) begin
        err_sticky <= 1'b0;
        err_count  <= '0;
      end

      if (state == ST_FAULT) begin
        // Recovery cycle: the sample presented now is deliberately ignored.
        state <= ST_HUNT;
      end else if (in_valid) begin
        if (dec_legal) begin
          ref_q       <= ring_in;
          phase_idx   <= dec_idx;
          phase_valid <= 1'b1;
        end else begin
          ref_q       <= '0;
          phase_valid <= 1'b0;
        end

        case (state)
          ST_HUNT: begin
            if (dec_legal) begin
              state    <= ST_CHECK;
              good_cnt <= '0;
            end
          end

          ST_CHECK: begin
            if (!dec_legal) begin
              state <= ST_HUNT;
            end else if (is_succ) begin
              if (good_cnt == GC_W'(LOCK_COUNT - 1)) begin
                state    <= ST_LOCKED;
                good_cnt <= '0;
              end else begin
                good_cnt <= good_cnt + GC_W'(1);
              end
            end else begin
              // Reseed or any other out-of-order legal sample restarts the run.
              good_cnt <= '0;
            end
          end

          ST_LOCKED: begin
            if (dec_legal && is_succ) begin
              if (is_seed) begin
                rot_count <= rot_count + ROT_W'(1);
              end
            end else if (dec_legal && is_seed && !is_stall) begin
              resync_pulse <= 1'b1;
            end else begin
              state      <= ST_FAULT;
              err_pulse  <= 1'b1;
              err_sticky <= 1'b1;
              if (clear_err) begin
                err_count <= ERR_W'(1);
              end else if (err_count != '1) begin
                err_count <= err_count + ERR_W'(1);
              end
            end
          end

          default: state <= ST_HUNT;
        endcase
      end
    end
  end

endmodule
